// File: rtl/ram_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// ram_bus_bridge_if
// PicoRV32 native memory bus, as seen between the CPU core and the RAM bridge.
//
// Signals:
//   mem_valid  CPU request valid
//   mem_addr   CPU byte address
//   mem_wdata  CPU write data
//   mem_wstrb  byte strobes, 4'b0000 means read
//   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid while mem_ready is high
//
// Modports:
//   master  CPU side (drives the request, samples the response)
//   slave   bridge side (samples the request, drives the response)
// ---------------------------------------------------------------------------
interface ram_bus_bridge_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/ram_bus_bridge.sv
// ---------------------------------------------------------------------------
// ram_bus_bridge
// Connects the PicoRV32 native memory bus to a word-wide on-chip RAM that has
// a single write port and no byte enables. Reads complete one cycle after
// acceptance. Every store (including full-word stores) goes through a
// read-modify-write: the old word is read combinationally while the request is
// accepted, merged with the strobed bytes, and written back in the next cycle.
//
// Optional feature (macro RAM_BRIDGE_OOR_EN):
//   When defined, a window hit whose word index is >= DEPTH_WORDS is answered
//   without touching the RAM (read data 0) and sets the sticky oor_err flag.
//   When undefined, every index goes to the RAM and oor_err is tied to 0.
//
// Parameters:
//   BASE_ADDR    window base; only bits [31:ADDR_BITS] are compared
//   ADDR_BITS    byte-address width of the RAM window
//   DEPTH_WORDS  physically backed words (range check only)
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          CPU memory bus (slave modport)
//   ram_wen      RAM write enable
//   ram_address  RAM byte address, bits [1:0] always 0
//   ram_wdata    RAM write word
//   ram_rdata    RAM combinational read data
//   oor_err      sticky out-of-range flag
// ---------------------------------------------------------------------------
module ram_bus_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 12,
  parameter int          DEPTH_WORDS = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_bus_bridge_if.slave      bus,
  output logic                 ram_wen,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic                 oor_err
);

  localparam int IDX_BITS = ADDR_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic                hit_s;
  logic                oor_s;
  logic [IDX_BITS-1:0] idx_s;
  logic                accept_rd_s;
  logic                accept_wr_s;
  logic                accept_oor_s;

  logic [IDX_BITS-1:0] addr_q_r;
  logic [31:0]         wq_r;
  logic [31:0]         mem_rdata_r;
  logic                mem_ready_r;

  // Byte-wise merge of the CPU store data into the current RAM word.
  function automatic logic [31:0] merge_word(
    input logic [31:0] new_word,
    input logic [31:0] old_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  // Window decode; address bits above ADDR_BITS take part only here.
  assign hit_s = bus.mem_valid &&
                 (bus.mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign idx_s = bus.mem_addr[ADDR_BITS-1:2];

`ifdef RAM_BRIDGE_OOR_EN
  assign oor_s = ({{(32-IDX_BITS){1'b0}}, idx_s} >= 32'(DEPTH_WORDS));

  logic unused_s;
  assign unused_s = ^{bus.mem_addr[1:0]};
`else
  assign oor_s = 1'b0;

  // DEPTH_WORDS only matters for the range check.
  logic unused_s;
  assign unused_s = ^{bus.mem_addr[1:0], 32'(DEPTH_WORDS)};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and request acceptance; hits are only looked at in IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    accept_rd_s  = 1'b0;
    accept_wr_s  = 1'b0;
    accept_oor_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          if (oor_s) begin
            accept_oor_s = 1'b1;
            state_nxt_s  = ST_ACK;
          end else if (bus.mem_wstrb == 4'b0000) begin
            accept_rd_s  = 1'b1;
            state_nxt_s  = ST_ACK;
          end else begin
            accept_wr_s  = 1'b1;
            state_nxt_s  = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_ACK;
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // RAM address mux: live CPU address in IDLE so the read/merge source is
  // available in the accept cycle, latched word address afterwards.
  always_comb begin
    ram_address = {addr_q_r, 2'b00};
    case (state_r)
      ST_IDLE: begin
        ram_address = {idx_s, 2'b00};
      end
      ST_WRITE: begin
        ram_address = {addr_q_r, 2'b00};
      end
      ST_ACK: begin
        ram_address = {addr_q_r, 2'b00};
      end
      default: begin
        ram_address = {addr_q_r, 2'b00};
      end
    endcase
  end

  // The write strobe is gated by rst so a reset during WRITE never corrupts
  // the target word.
  assign ram_wen   = (state_r == ST_WRITE) && !rst;
  assign ram_wdata = wq_r;

  // Request capture: word address, merged store word, read data and the
  // completion pulse (high exactly in the ACK cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
      wq_r        <= 32'h0000_0000;
      addr_q_r    <= {IDX_BITS{1'b0}};
    end else begin
      mem_ready_r <= (state_nxt_s == ST_ACK);
      if (accept_rd_s || accept_wr_s || accept_oor_s) begin
        addr_q_r <= idx_s;
      end
      if (accept_rd_s) begin
        mem_rdata_r <= ram_rdata;
      end else if (accept_oor_s) begin
        mem_rdata_r <= 32'h0000_0000;
      end
      if (accept_wr_s) begin
        wq_r <= merge_word(bus.mem_wdata, ram_rdata, bus.mem_wstrb);
      end
    end
  end

  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_rdata_r;

`ifdef RAM_BRIDGE_OOR_EN
  logic oor_err_r;

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      oor_err_r <= 1'b0;
    end else if (accept_oor_s) begin
      oor_err_r <= 1'b1;
    end
  end

  assign oor_err = oor_err_r;
`else
  assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_bridge.sv
module tb_ram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_wen;
  logic [11:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        oor_err;

  ram_bus_bridge_if bus ();

  ram_bus_bridge #(
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_BITS  (12),
    .DEPTH_WORDS(512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_wen    (ram_wen),
    .ram_address(ram_address),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .oor_err    (oor_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: combinational read, write on the rising edge.
  logic [31:0] ram_mem [0:1023];
  assign ram_rdata = ram_mem[ram_address[11:2]];
  always @(posedge clk) if (ram_wen) ram_mem[ram_address[11:2]] <= ram_wdata;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        chk;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  int n_vec     = 0;
  int n_err     = 0;
  int ready_cnt = 0;
  int wen_cnt   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every mem_ready / ram_wen cycle.
  always @(negedge clk) begin : monitor
    rsp_t e;
    wr_t  w;
    if (bus.mem_ready === 1'b1) begin
      ready_cnt++;
      if (rsp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = rsp_q.pop_front();
        check32("ready_cycle", 32'(cyc), 32'(e.cyc));
        if (e.chk) check32("mem_rdata", bus.mem_rdata, e.rdata);
      end
    end
    if (ram_wen === 1'b1) begin
      wen_cnt++;
      if (wr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wen: actual=1 required=0 addr=%h (cycle %0d)", ram_address, cyc);
      end else begin
        w = wr_q.pop_front();
        check32("wen_cycle", 32'(cyc), 32'(w.cyc));
        check32("ram_address", {20'h0, ram_address}, {20'h0, w.addr});
        check32("ram_wdata", ram_wdata, w.data);
      end
    end
  end

  // Issue one request (called #1 after a rising edge with the DUT idle), queue
  // its expected response and wait, bounded, for completion.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input int lat, input logic chk, input logic [31:0] exp_rd,
                       input logic exp_wr, input logic [31:0] exp_word);
    rsp_t e;
    wr_t  w;
    int   i;
    e.cyc = cyc + lat; e.rdata = exp_rd; e.chk = chk;
    rsp_q.push_back(e);
    if (exp_wr) begin
      w.cyc = cyc + 1; w.addr = addr[11:0] & 12'hFFC; w.data = exp_word;
      wr_q.push_back(w);
    end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    for (i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) break;
    end
    n_vec++;
    if (i == 12) begin
      n_err++;
      $display("FAIL ready_timeout: actual=none required=ready addr=%h", addr);
      rsp_q.delete();
      wr_q.delete();
    end
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [31:0] merged);
    issue(addr, data, strb, 2, 1'b0, 32'h0, 1'b1, merged);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    issue(addr, 32'h0, 4'b0000, 1, 1'b1, exp, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;

    // Reset held with a pending hit read.
    rst           = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      check32("rst_mem_ready", {31'h0, bus.mem_ready}, 32'h0);
      check32("rst_ram_wen", {31'h0, ram_wen}, 32'h0);
      check32("rst_mem_rdata", bus.mem_rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(32'h0000_0010, 32'h0000_0000);

    // Full write then read.
    wr(32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    rd(32'h0000_0010, 32'hDEADBEEF);

    // Byte RMW.
    wr(32'h0000_0020, 32'h11223344, 4'hF, 32'h11223344);
    wr(32'h0000_0020, 32'hAABBCCDD, 4'b0100, 32'h11BB3344);
    rd(32'h0000_0020, 32'h11BB3344);

    // Halfword RMW, then a split-byte store on the same word.
    wr(32'h0000_0024, 32'h00000000, 4'hF, 32'h00000000);
    wr(32'h0000_0024, 32'h12345678, 4'b0011, 32'h00005678);
    rd(32'h0000_0024, 32'h00005678);
    wr(32'h0000_0026, 32'hCAFEF00D, 4'b1001, 32'hCA00560D);
    rd(32'h0000_0024, 32'hCA00560D);

    // Miss: write outside the window, held for 5 cycles.
    r0 = ready_cnt;
    w0 = wen_cnt;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_1000;
    bus.mem_wdata = 32'hFFFF_FFFF;
    bus.mem_wstrb = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    check32("miss_ready_cnt", 32'(ready_cnt), 32'(r0));
    check32("miss_wen_cnt", 32'(wen_cnt), 32'(w0));

    // Reset asserted during WRITE: no RAM write, no ready.
    r0 = ready_cnt;
    w0 = wen_cnt;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wdata = 32'h5555_5555;
    bus.mem_wstrb = 4'hF;
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    @(negedge clk);
    check32("rstw_ram_wen", {31'h0, ram_wen}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rstw_ready_cnt", 32'(ready_cnt), 32'(r0));
    check32("rstw_wen_cnt", 32'(wen_cnt), 32'(w0));
    rd(32'h0000_0010, 32'hDEADBEEF);

`ifdef RAM_BRIDGE_OOR_EN
    // Index 576 is beyond the 512 backed words.
    check32("oor_err_before", {31'h0, oor_err}, 32'h0);
    issue(32'h0000_0900, 32'h12345678, 4'hF, 1, 1'b1, 32'h0, 1'b0, 32'h0);
    check32("oor_err_set", {31'h0, oor_err}, 32'h1);
    issue(32'h0000_0900, 32'h0, 4'b0000, 1, 1'b1, 32'h0, 1'b0, 32'h0);
    check32("oor_err_sticky", {31'h0, oor_err}, 32'h1);
    rd(32'h0000_0010, 32'hDEADBEEF);
    check32("oor_err_held", {31'h0, oor_err}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check32("oor_err_cleared", {31'h0, oor_err}, 32'h0);
`else
    // Highest index in the window goes straight to the RAM.
    wr(32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF, 32'hA5A5_5A5A);
    rd(32'h0000_0FFC, 32'hA5A5_5A5A);
    wr(32'h0000_0900, 32'h0BAD_F00D, 4'b0010, 32'h0000_F000);
    rd(32'h0000_0900, 32'h0000_F000);
    check32("oor_err_tied", {31'h0, oor_err}, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check32("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    check32("wr_q_empty", 32'(wr_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_bus_bridge.md
# ram_bus_bridge

Bridges the PicoRV32 native memory interface to the word-wide, single-write-port on-chip RAM. Decodes the RAM address window, returns read data with a registered `mem_ready` handshake, and turns byte/halfword stores into read-modify-write sequences, because the RAM has no byte enables. Sits between the CPU core and the RAM instance.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: window base; only bits [31:ADDR_BITS] are compared.
- `ADDR_BITS`, 12: byte-address width of the RAM window.
- `DEPTH_WORDS`, 512: number of physically backed words; used only with `RAM_BRIDGE_OOR_EN`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_valid` in 1: CPU request valid.
- `mem_addr` in 32: CPU byte address.
- `mem_wdata` in 32: CPU write data.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `mem_ready` out 1: one-cycle completion pulse for a window hit.
- `mem_rdata` out 32: registered read data; valid while `mem_ready`=1.
- `ram_wen` out 1: RAM write enable.
- `ram_address` out ADDR_BITS: RAM byte address; bits [1:0] are always 0.
- `ram_wdata` out 32: RAM write word.
- `ram_rdata` in 32: RAM combinational read data.
- `oor_err` out 1: sticky out-of-range flag; constant 0 without `RAM_BRIDGE_OOR_EN`.

## Operation
- `hit` = `mem_valid` && (`mem_addr`[31:ADDR_BITS] == `BASE_ADDR`[31:ADDR_BITS]). The bridge ignores misses: no `mem_ready`, no RAM write.
- The FSM has three states: IDLE, WRITE and ACK.
- **IDLE**
  - `ram_address` = {`mem_addr`[ADDR_BITS-1:2], 2'b00}.
  - On `hit`, latch the word address into `addr_q`.
  - Read (`mem_wstrb`==0): capture `ram_rdata` into `mem_rdata`, then go to ACK.
  - Write: compute the merged word `wq` and go to WRITE. For each byte i, byte i of `wq` = `mem_wstrb`[i] ? `mem_wdata` byte i : `ram_rdata` byte i.
  - Full-word writes (strobe 4'hF) take the same path; they are not special-cased.
- **WRITE**
  - `ram_address` = `addr_q`.
  - `ram_wdata` = `wq`.
  - `ram_wen` = 1.
  - Go to ACK.
- **ACK**
  - `mem_ready` = 1 for this cycle only.
  - Return to IDLE unconditionally.
- `ram_wen` = (state==WRITE) && !`rst`. It is never asserted in any other state.
- `ram_wdata` = `wq` in all states; it only matters in WRITE.
- `mem_rdata` holds its last value outside reads. The CPU samples it only when `mem_ready`=1.
- A `hit` is only evaluated in IDLE. Changes to `mem_valid`/`mem_addr` while in WRITE or ACK are ignored.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `mem_rdata`=0, `ram_wen`=0, `wq`=0, `addr_q`=0, `oor_err`=0.
- Read latency: request accepted in cycle N, `mem_ready`=1 in cycle N+1.
- Write latency: request accepted in cycle N, `ram_wen`=1 in cycle N+1, `mem_ready`=1 in cycle N+2.
- Throughput: the earliest next acceptance is the cycle after ACK. Back-to-back reads take 2 cycles each; writes take 3.
- RAM read-after-write: a read accepted the cycle after a write's ACK returns the new word, since the RAM write completed at the end of WRITE.
- `rst` asserted in any state, including WRITE:
  - the RAM is not written that cycle;
  - the pending transaction is dropped with no `mem_ready`;
  - the next cycle is IDLE.
- Address wrap: the word index is `mem_addr`[ADDR_BITS-1:2]. Bits above ADDR_BITS only participate in the hit decode.

## Configuration
- **`RAM_BRIDGE_OOR_EN` defined:**
  - In IDLE, a hit whose word index is ≥ `DEPTH_WORDS` is out of range.
  - It completes via ACK in cycle N+1 for both reads and writes.
  - `mem_rdata` = 0 and no RAM write occurs.
  - `oor_err` is set the cycle after acceptance and stays set until `rst`.
- **Not defined:** no range check. Every index is passed to the RAM, and `oor_err` is tied to 0.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` 2 cycles with `mem_valid`=1, hit.
  - Required: `mem_ready`=0, `ram_wen`=0, `mem_rdata`=0 throughout; first acceptance occurs in the cycle after `rst` falls.
- **Full write then read:**
  - Stimulus: write 32'hDEADBEEF, strobe 4'hF, to address 0x010; then read 0x010.
  - Required: `ram_wen`=1 exactly one cycle with `ram_address`=0x010; write `mem_ready` at N+2; read `mem_ready` at M+1 with `mem_rdata`=32'hDEADBEEF.
- **Byte RMW:**
  - Stimulus: preload 0x020 with 32'h11223344; write `mem_wdata`=32'hAABBCCDD, strobe 4'b0100; read back.
  - Required: `ram_wdata`=32'h11BB3344 during WRITE; readback returns 32'h11BB3344.
- **Halfword RMW:**
  - Stimulus: preload 0x024 with 32'h00000000; write 32'h12345678 with strobe 4'b0011.
  - Required: stored word is 32'h00005678.
- **Miss and reset-in-WRITE:**
  - Stimulus: a write to 0x0000_1000 (outside the window); separately, assert `rst` during WRITE.
  - Required for the miss: no `ram_wen`, no `mem_ready` for 5 cycles.
  - Required for reset-in-WRITE: the target word is unchanged and no `mem_ready` occurs.
- **Out of range (`RAM_BRIDGE_OOR_EN` defined, `DEPTH_WORDS`=512):**
  - Stimulus: write 0x900 (index 576), then read 0x900.
  - Required for the write: `ram_wen` stays 0 and `mem_ready` at N+1.
  - Required for the read: `mem_rdata`=0.
  - `oor_err`=1 until `rst`.
